// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access codes, the I/O
// memory map and the region type produced by the address decoder.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // A region hits when addr[31:2] matches its base, so the low two bits are masked.
  localparam logic [31:0] REGION_MASK = 32'hFFFF_FFFC;

  localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
  localparam logic [31:0] HEXLO_BASE = 32'h1000_2000;
  localparam logic [31:0] HEXHI_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE   = 32'h1000_4000;
  localparam logic [31:0] SW_BASE    = 32'h1001_0000;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DMEM,
    REG_LEDR,
    REG_LEDG,
    REG_HEXLO,
    REG_HEXHI,
    REG_LCD,
    REG_SW
  } region_e;

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: word array with per-byte write enables, synchronous write
// and asynchronous read. Contents are deliberately not reset.
module lsu_dmem #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lsu.sv
// Load/store unit: address decode, byte-lane alignment, load extension,
// board I/O registers and the switch synchronizer.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 512,
  parameter int SW_SYNC    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsuAddr,
  input  logic [31:0] i_stData,
  input  logic        i_lsuWren,
  input  logic [2:0]  i_lsuOp,
  output logic [31:0] o_ldData,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hexLo,
  output logic [31:0] o_io_hexHi,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int AW = $clog2(DMEM_WORDS);

  region_e     region;
  logic        misaligned, store_op, wr_en;
  logic [3:0]  byte_en;
  logic [31:0] wdata, wmask, rd_word, lane, dmem_rdata;
  logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;
  logic [31:0] sw_sync [SW_SYNC];

  always_comb begin
    region = REG_NONE;
    if ((i_lsuAddr >> (AW + 2)) == 32'd0) begin
      region = REG_DMEM;
    end else begin
      case (i_lsuAddr & REGION_MASK)
        LEDR_BASE:  region = REG_LEDR;
        LEDG_BASE:  region = REG_LEDG;
        HEXLO_BASE: region = REG_HEXLO;
        HEXHI_BASE: region = REG_HEXHI;
        LCD_BASE:   region = REG_LCD;
        SW_BASE:    region = REG_SW;
        default:    region = REG_NONE;
      endcase
    end
  end

  // Unsigned codes and unused funct3 values never store.
  always_comb begin
    misaligned = 1'b0;
    store_op   = 1'b0;
    byte_en    = 4'b0000;
    wdata      = i_stData;
    case (i_lsuOp)
      LSU_B: begin
        store_op = 1'b1;
        byte_en  = 4'b0001 << i_lsuAddr[1:0];
        wdata    = {4{i_stData[7:0]}};
      end
      LSU_H: begin
        store_op   = 1'b1;
        misaligned = i_lsuAddr[0];
        byte_en    = i_lsuAddr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{i_stData[15:0]}};
      end
      LSU_W: begin
        store_op   = 1'b1;
        misaligned = |i_lsuAddr[1:0];
        byte_en    = 4'b1111;
      end
      LSU_HU:  misaligned = i_lsuAddr[0];
      default: ;
    endcase
  end

  assign wr_en = i_lsuWren && store_op && !misaligned && i_rst_n;
  assign wmask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

  lsu_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk   (i_clk),
    .we    (wr_en && (region == REG_DMEM)),
    .be    (byte_en),
    .addr  (i_lsuAddr[AW+1:2]),
    .wdata (wdata),
    .rdata (dmem_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr   <= '0;
      ledg   <= '0;
      hex_lo <= '0;
      hex_hi <= '0;
      lcd    <= '0;
    end else if (wr_en) begin
      case (region)
        REG_LEDR:  ledr   <= (ledr   & ~wmask) | (wdata & wmask);
        REG_LEDG:  ledg   <= (ledg   & ~wmask) | (wdata & wmask);
        REG_HEXLO: hex_lo <= (hex_lo & ~wmask) | (wdata & wmask);
        REG_HEXHI: hex_hi <= (hex_hi & ~wmask) | (wdata & wmask);
        REG_LCD:   lcd    <= (lcd    & ~wmask) | (wdata & wmask);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SW_SYNC; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= i_io_sw;
      for (int i = 1; i < SW_SYNC; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  always_comb begin
    case (region)
      REG_DMEM:  rd_word = dmem_rdata;
      REG_LEDR:  rd_word = ledr;
      REG_LEDG:  rd_word = ledg;
      REG_HEXLO: rd_word = hex_lo;
      REG_HEXHI: rd_word = hex_hi;
      REG_LCD:   rd_word = lcd;
      REG_SW:    rd_word = sw_sync[SW_SYNC-1];
      default:   rd_word = '0;
    endcase
  end

  assign lane = rd_word >> {i_lsuAddr[1:0], 3'b000};

  always_comb begin
    o_ldData = '0;
    if (!misaligned) begin
      case (i_lsuOp)
        LSU_B:   o_ldData = {{24{lane[7]}}, lane[7:0]};
        LSU_H:   o_ldData = {{16{lane[15]}}, lane[15:0]};
        LSU_W:   o_ldData = lane;
        LSU_BU:  o_ldData = {24'd0, lane[7:0]};
        LSU_HU:  o_ldData = {16'd0, lane[15:0]};
        default: o_ldData = '0;
      endcase
    end
  end

  assign o_misaligned = misaligned;
  assign o_io_ledr    = ledr;
  assign o_io_ledg    = ledg;
  assign o_io_hexLo   = hex_lo;
  assign o_io_hexHi   = hex_hi;
  assign o_io_lcd     = lcd;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected values are queued as stimulus is
// driven and drained against the DUT outputs once they are due.
module tb_lsu;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] i_lsuAddr = '0;
  logic [31:0] i_stData = '0;
  logic        i_lsuWren = 1'b0;
  logic [2:0]  i_lsuOp = LSU_W;
  logic [31:0] i_io_sw = '0;
  logic [31:0] o_ldData, o_io_ledr, o_io_ledg, o_io_hexLo, o_io_hexHi, o_io_lcd;
  logic        o_misaligned;

  lsu #(.DMEM_WORDS(512), .SW_SYNC(2)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_lsuAddr    (i_lsuAddr),
    .i_stData     (i_stData),
    .i_lsuWren    (i_lsuWren),
    .i_lsuOp      (i_lsuOp),
    .o_ldData     (o_ldData),
    .o_misaligned (o_misaligned),
    .o_io_ledr    (o_io_ledr),
    .o_io_ledg    (o_io_ledg),
    .o_io_hexLo   (o_io_hexLo),
    .o_io_hexHi   (o_io_hexHi),
    .o_io_lcd     (o_io_lcd),
    .i_io_sw      (i_io_sw)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic expect_val(input string name, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    sb.push_back(e);
  endtask

  // Stores are set up on the falling edge and committed on the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] op);
    @(negedge i_clk);
    i_lsuAddr = addr;
    i_stData  = data;
    i_lsuOp   = op;
    i_lsuWren = 1'b1;
    @(posedge i_clk);
    #1;
    i_lsuWren = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] op);
    @(negedge i_clk);
    i_lsuAddr = addr;
    i_lsuOp   = op;
    i_lsuWren = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] ob;
    i_rst_n = 1'b0;
    #2;
    foreach (obs[i]) obs.delete(i);
    expect_val("rst_ledr", 32'h0);  obs.push_back(o_io_ledr);
    expect_val("rst_ledg", 32'h0);  obs.push_back(o_io_ledg);
    expect_val("rst_hexlo", 32'h0); obs.push_back(o_io_hexLo);
    expect_val("rst_hexhi", 32'h0); obs.push_back(o_io_hexHi);
    expect_val("rst_lcd", 32'h0);   obs.push_back(o_io_lcd);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_word();
    exp_t        e;
    logic [31:0] ob;
    store(32'h10, 32'hDEADBEEF, LSU_W);
    load(32'h10, LSU_W);
    expect_val("lw_10", 32'hDEADBEEF); obs.push_back(o_ldData);
    expect_val("lw_10_mis", 32'h0);    obs.push_back({31'd0, o_misaligned});
    store(32'h7FC, 32'h0BADF00D, LSU_W);
    store(32'h800, 32'h55555555, LSU_W);
    load(32'h7FC, LSU_W);
    expect_val("lw_dmem_top", 32'h0BADF00D); obs.push_back(o_ldData);
    load(32'h800, LSU_W);
    expect_val("lw_unmapped", 32'h0); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_byte();
    exp_t        e;
    logic [31:0] ob;
    store(32'h13, 32'h00000080, LSU_B);
    load(32'h13, LSU_B);
    expect_val("lb_13", 32'hFFFFFF80);  obs.push_back(o_ldData);
    load(32'h13, LSU_BU);
    expect_val("lbu_13", 32'h00000080); obs.push_back(o_ldData);
    load(32'h10, LSU_W);
    expect_val("lw_10_after_sb", 32'h80ADBEEF); obs.push_back(o_ldData);
    load(32'h12, LSU_H);
    expect_val("lh_12", 32'hFFFF80AD);  obs.push_back(o_ldData);
    load(32'h12, LSU_HU);
    expect_val("lhu_12", 32'h000080AD); obs.push_back(o_ldData);
    load(32'h10, LSU_H);
    expect_val("lh_10", 32'hFFFFBEEF);  obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t        e;
    logic [31:0] ob;
    @(negedge i_clk);
    i_lsuAddr = 32'h11;
    i_stData  = 32'h0000BEEF;
    i_lsuOp   = LSU_H;
    i_lsuWren = 1'b1;
    #1;
    expect_val("sh_11_mis", 32'h1);  obs.push_back({31'd0, o_misaligned});
    expect_val("sh_11_data", 32'h0); obs.push_back(o_ldData);
    @(posedge i_clk);
    #1;
    i_lsuWren = 1'b0;
    load(32'h10, LSU_W);
    expect_val("lw_10_after_sh", 32'h80ADBEEF); obs.push_back(o_ldData);
    load(32'h12, LSU_W);
    expect_val("lw_12_mis", 32'h1);  obs.push_back({31'd0, o_misaligned});
    expect_val("lw_12_data", 32'h0); obs.push_back(o_ldData);
    load(32'h10, 3'b011);
    expect_val("op011_data", 32'h0); obs.push_back(o_ldData);
    expect_val("op011_mis", 32'h0);  obs.push_back({31'd0, o_misaligned});
    store(32'h10, 32'h00000055, LSU_BU);
    store(32'h10, 32'h00000055, 3'b110);
    load(32'h10, LSU_W);
    expect_val("lw_10_after_bu", 32'h80ADBEEF); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_io();
    exp_t        e;
    logic [31:0] ob;
    store(LEDR_BASE, 32'h12345678, LSU_W);
    expect_val("ledr_sw", 32'h12345678); obs.push_back(o_io_ledr);
    store(LEDR_BASE + 32'd1, 32'h000000AA, LSU_B);
    expect_val("ledr_sb", 32'h1234AA78); obs.push_back(o_io_ledr);
    load(LEDR_BASE, LSU_W);
    expect_val("ledr_lw", 32'h1234AA78); obs.push_back(o_ldData);
    store(LEDG_BASE, 32'hA5A5_0F0F, LSU_W);
    expect_val("ledg_sw", 32'hA5A50F0F); obs.push_back(o_io_ledg);
    store(HEXHI_BASE + 32'd2, 32'h0000C3C3, LSU_H);
    expect_val("hexhi_sh", 32'hC3C30000); obs.push_back(o_io_hexHi);
    store(LCD_BASE, 32'h0000_0123, LSU_W);
    expect_val("lcd_sw", 32'h00000123); obs.push_back(o_io_lcd);
    store(32'h2000_0000, 32'hFFFF_FFFF, LSU_W);
    load(32'h2000_0000, LSU_W);
    expect_val("unmapped_ld", 32'h0); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_sw_sync();
    exp_t        e;
    logic [31:0] ob;
    @(negedge i_clk);
    i_io_sw   = 32'h5A;
    i_lsuAddr = SW_BASE;
    i_lsuOp   = LSU_W;
    i_lsuWren = 1'b0;
    @(posedge i_clk);
    #1;
    expect_val("sw_1_edge", 32'h0);  obs.push_back(o_ldData);
    @(posedge i_clk);
    #1;
    expect_val("sw_2_edge", 32'h5A); obs.push_back(o_ldData);
    store(SW_BASE, 32'h12345678, LSU_W);
    load(SW_BASE, LSU_W);
    expect_val("sw_ro", 32'h5A); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] ob;
    store(32'h20, 32'h11111111, LSU_W);
    @(negedge i_clk);
    i_lsuAddr = 32'h20;
    i_stData  = 32'h22222222;
    i_lsuOp   = LSU_W;
    i_lsuWren = 1'b1;
    #1;
    expect_val("same_cycle_old", 32'h11111111); obs.push_back(o_ldData);
    @(posedge i_clk);
    #1;
    i_lsuWren = 1'b0;
    expect_val("same_cycle_new", 32'h22222222); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t        e;
    logic [31:0] ob;
    store(HEXLO_BASE, 32'h000000FF, LSU_W);
    expect_val("hexlo_pre", 32'hFF); obs.push_back(o_io_hexLo);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    expect_val("arst_ledr", 32'h0);  obs.push_back(o_io_ledr);
    expect_val("arst_ledg", 32'h0);  obs.push_back(o_io_ledg);
    expect_val("arst_hexlo", 32'h0); obs.push_back(o_io_hexLo);
    expect_val("arst_hexhi", 32'h0); obs.push_back(o_io_hexHi);
    expect_val("arst_lcd", 32'h0);   obs.push_back(o_io_lcd);
    @(negedge i_clk);
    i_lsuAddr = 32'h10;
    i_stData  = 32'h0;
    i_lsuOp   = LSU_W;
    i_lsuWren = 1'b1;
    @(posedge i_clk);
    #1;
    i_lsuWren = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    load(SW_BASE, LSU_W);
    expect_val("sw_after_rst", 32'h0); obs.push_back(o_ldData);
    load(32'h10, LSU_W);
    expect_val("dmem_kept", 32'h80ADBEEF); obs.push_back(o_ldData);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = obs.pop_front();
      vectors++;
      if (ob !== e.value) begin
        $display("[TB] FAIL %s: got %h expected %h", e.name, ob, e.value);
        miscompares++;
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_io();
    test_sw_sync();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
